// File: rtl/cp0_timer_ctrl_if.sv
// cp0_timer_ctrl_if: pipeline <-> CP0 bus.
// Carries the MTC0/MFC0 register access and the exception/ERET commit signals.
// The master side is the pipeline (memory/write-back stage); the slave side is CP0.
interface cp0_timer_ctrl_if;
    // MTC0 write port
    logic        mtc0_we;
    logic [4:0]  mtc0_addr;
    logic [31:0] mtc0_wdata;
    // MFC0 read port (combinational read data)
    logic [4:0]  mfc0_addr;
    logic [31:0] mfc0_rdata;
    // precise exception / ERET commit
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic        exc_badv_we;
    logic [31:0] exc_badvaddr;
    logic        eret;

    modport master (
        output mtc0_we, mtc0_addr, mtc0_wdata, mfc0_addr,
        output exc_valid, exc_code, exc_pc, exc_bd, exc_badv_we, exc_badvaddr, eret,
        input  mfc0_rdata
    );

    modport slave (
        input  mtc0_we, mtc0_addr, mtc0_wdata, mfc0_addr,
        input  exc_valid, exc_code, exc_pc, exc_bd, exc_badv_we, exc_badvaddr, eret,
        output mfc0_rdata
    );
endinterface

// File: rtl/cp0_timer_ctrl.sv
// cp0_timer_ctrl: MIPS CP0 register file with Count/Compare timer and
// precise exception-commit / ERET handling.
// Optional feature macro: CP0_TIMER_EN
//   defined     - prescaled Count, Compare and the Cause.TI timer interrupt
//   not defined - no timer storage; regs 9/11 read 0, TI is constant 0
// Same-cycle commit priority: exception > ERET > MTC0.
module cp0_timer_ctrl #(
    parameter int          NUM_HW_INT   = 6,
    parameter int          COUNT_DIV    = 2,
    parameter logic [31:0] PRID_VALUE   = 32'h0000_4220,
    parameter logic [31:0] CONFIG_VALUE = 32'h0000_8000
) (
    input  logic                  clk,
    input  logic                  rst,
    cp0_timer_ctrl_if.slave       bus,
    input  logic [NUM_HW_INT-1:0] hw_int_i,
    output logic                  int_req_o,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;
    localparam logic [4:0] REG_CONFIG   = 5'd16;

    // Writable architectural state outside the timer.
    typedef struct packed {
        logic [31:0] badvaddr;
        logic [7:0]  im;        // Status.IM
        logic        exl;       // Status.EXL
        logic        ie;        // Status.IE
        logic        bd;        // Cause.BD
        logic [1:0]  ip_sw;     // Cause.IP[1:0] (software interrupts)
        logic [4:0]  exc_code;  // Cause.ExcCode
        logic [31:0] epc;
    } core_t;

    core_t                 core_q, core_d;
    logic [NUM_HW_INT-1:0] hw_q;
    logic                  ti;
    logic [7:0]            ip;

    // Commit arbitration: a lower-priority commit is dropped, never deferred.
    logic do_exc, do_eret, do_mtc0;
    assign do_exc  = bus.exc_valid;
    assign do_eret = ~bus.exc_valid & bus.eret;
    assign do_mtc0 = ~bus.exc_valid & ~bus.eret & bus.mtc0_we;

    // Next-state for the non-timer registers.
    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        core_d = core_q;
        if (do_exc) begin
            if (!core_q.exl) begin
                core_d.epc = bus.exc_pc;
                core_d.bd  = bus.exc_bd;
            end
            core_d.exl      = 1'b1;
            core_d.exc_code = bus.exc_code;
            if (bus.exc_badv_we) core_d.badvaddr = bus.exc_badvaddr;
        end else if (do_eret) begin
            core_d.exl = 1'b0;
        end else if (do_mtc0) begin
            case (bus.mtc0_addr)
                REG_BADVADDR: core_d.badvaddr = bus.mtc0_wdata;
                REG_STATUS: begin
                    core_d.im  = bus.mtc0_wdata[15:8];
                    core_d.exl = bus.mtc0_wdata[1];
                    core_d.ie  = bus.mtc0_wdata[0];
                end
                REG_CAUSE:    core_d.ip_sw = bus.mtc0_wdata[9:8];
                REG_EPC:      core_d.epc   = bus.mtc0_wdata;
                default:      ;
            endcase
        end
    end

    // Non-timer state register; hardware interrupt lines are sampled every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_q <= '0;
            hw_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            core_q <= core_d;
            hw_q   <= hw_int_i;
        end
    end

`ifdef CP0_TIMER_EN
    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [31:0]   count_q, count_d;
    logic [31:0]   compare_q, compare_d;
    logic          ti_q, ti_d;
    logic          wr_count, wr_compare;

    assign wr_count   = do_mtc0 && (bus.mtc0_addr == REG_COUNT);
    assign wr_compare = do_mtc0 && (bus.mtc0_addr == REG_COMPARE);

    // Prescaler, Count increment and sticky TI; a Compare write clears TI last so it wins.
    always_comb begin
        presc_d   = presc_q;
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q;
        if (wr_count) begin
            count_d = bus.mtc0_wdata;
            presc_d = '0;
        end else if (presc_q == PW'(COUNT_DIV - 1)) begin
            presc_d = '0;
            count_d = count_q + 32'd1;
            if (count_q + 32'd1 == compare_q) ti_d = 1'b1;
        end else begin
            presc_d = presc_q + 1'b1;
        end
        if (wr_compare) begin
            compare_d = bus.mtc0_wdata;
            ti_d      = 1'b0;
        end
    end

    // Timer state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q   <= '0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign ti = ti_q;
`else
    assign ti = 1'b0;
`endif

    // Cause.IP view: software bits, sampled hardware lines, TI folded into IP[7].
    always_comb begin
        ip      = '0;
        ip[1:0] = core_q.ip_sw;
        for (int i = 0; i < NUM_HW_INT; i++) ip[2+i] = hw_q[i];
        ip[7]   = ip[7] | ti;
    end

    assign status_o  = {9'b0, 1'b1, 6'b0, core_q.im, 6'b0, core_q.exl, core_q.ie};
    assign cause_o   = {core_q.bd, ti, 14'b0, ip, 1'b0, core_q.exc_code, 2'b0};
    assign epc_o     = core_q.epc;
    assign int_req_o = core_q.ie & ~core_q.exl & (|(ip & core_q.im));

    // MFC0 read mux: pre-edge register values, unimplemented numbers read 0.
    always_comb begin
        bus.mfc0_rdata = 32'h0;
        case (bus.mfc0_addr)
            REG_BADVADDR: bus.mfc0_rdata = core_q.badvaddr;
`ifdef CP0_TIMER_EN
            REG_COUNT:    bus.mfc0_rdata = count_q;
            REG_COMPARE:  bus.mfc0_rdata = compare_q;
`endif
            REG_STATUS:   bus.mfc0_rdata = status_o;
            REG_CAUSE:    bus.mfc0_rdata = cause_o;
            REG_EPC:      bus.mfc0_rdata = core_q.epc;
            REG_PRID:     bus.mfc0_rdata = PRID_VALUE;
            REG_CONFIG:   bus.mfc0_rdata = CONFIG_VALUE;
            default:      ;
        endcase
    end

endmodule
